// File: rtl/cr_ifu_lockup_resp.sv
// IFU responder to the IU lockup handshake: blocks new fetches, drains the
// outstanding ones, acknowledges, and holds fetch off while the IU masks it.
module cr_ifu_lockup_resp #(
   parameter int OUTST_MAX = 2,
   parameter int CNT_W     = 2
) (
   input  logic             misc_clk,
   input  logic             cpurst_b,
   input  logic             iu_ifu_lockup_req,
   input  logic             iu_ifu_lockup_mask,
   input  logic             iu_ifu_lockup_on,
   output logic             ifu_iu_lockup_ack,
   input  logic             pref_ifu_req,
   output logic             ifu_pref_stall,
   output logic             ifu_bus_req,
   input  logic             bus_ifu_grnt,
   input  logic             bus_ifu_trans_cmplt,
   output logic [CNT_W-1:0] ifu_lockup_outst_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2,
      LOCK  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTST_MAX);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_inc, cnt_dec;

   // State register
   always_ff @(posedge misc_clk or negedge cpurst_b) begin
      if (!cpurst_b) state <= IDLE;
      else           state <= state_nxt;
   end

   // Next-state logic; an NMI re-lockup out of LOCK outranks the mask release.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (iu_ifu_lockup_req) state_nxt = DRAIN;
         DRAIN:   if (cnt == '0) state_nxt = ACK;
         ACK: begin
            if (!iu_ifu_lockup_req) state_nxt = iu_ifu_lockup_on ? LOCK : IDLE;
         end
         LOCK: begin
            if (iu_ifu_lockup_req)       state_nxt = DRAIN;
            else if (!iu_ifu_lockup_mask) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Fetch gating; the reset term keeps the bus request low while in reset.
   always_comb begin
      ifu_bus_req = cpurst_b && pref_ifu_req && (state == IDLE) &&
                    !iu_ifu_lockup_req && !iu_ifu_lockup_mask && (cnt < CNT_MAX);
      ifu_pref_stall = pref_ifu_req && !ifu_bus_req;
   end

   // Outstanding counter; completions seen at zero (e.g. after reset) are dropped.
   always_comb begin
      cnt_inc = ifu_bus_req && bus_ifu_grnt;
      cnt_dec = bus_ifu_trans_cmplt && (cnt != '0);
      cnt_nxt = cnt;
      if (cnt_inc && !cnt_dec)      cnt_nxt = cnt + CNT_W'(1);
      else if (cnt_dec && !cnt_inc) cnt_nxt = cnt - CNT_W'(1);
   end

   always_ff @(posedge misc_clk or negedge cpurst_b) begin
      if (!cpurst_b) cnt <= '0;
      else           cnt <= cnt_nxt;
   end

   // Ack is a pure decode of the state register: no input-to-ack path.
   assign ifu_iu_lockup_ack    = (state == ACK);
   assign ifu_lockup_outst_cnt = cnt;

endmodule

// File: tb/tb_cr_ifu_lockup_resp.sv
// Directed bench for cr_ifu_lockup_resp: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_cr_ifu_lockup_resp;

   logic       misc_clk = 1'b0;
   logic       cpurst_b;
   logic       iu_ifu_lockup_req, iu_ifu_lockup_mask, iu_ifu_lockup_on;
   logic       ifu_iu_lockup_ack;
   logic       pref_ifu_req, ifu_pref_stall, ifu_bus_req;
   logic       bus_ifu_grnt, bus_ifu_trans_cmplt;
   logic [1:0] ifu_lockup_outst_cnt;

   cr_ifu_lockup_resp #(.OUTST_MAX(2), .CNT_W(2)) dut (
      .misc_clk             (misc_clk),
      .cpurst_b             (cpurst_b),
      .iu_ifu_lockup_req    (iu_ifu_lockup_req),
      .iu_ifu_lockup_mask   (iu_ifu_lockup_mask),
      .iu_ifu_lockup_on     (iu_ifu_lockup_on),
      .ifu_iu_lockup_ack    (ifu_iu_lockup_ack),
      .pref_ifu_req         (pref_ifu_req),
      .ifu_pref_stall       (ifu_pref_stall),
      .ifu_bus_req          (ifu_bus_req),
      .bus_ifu_grnt         (bus_ifu_grnt),
      .bus_ifu_trans_cmplt  (bus_ifu_trans_cmplt),
      .ifu_lockup_outst_cnt (ifu_lockup_outst_cnt)
   );

   always #5 misc_clk = ~misc_clk;

   typedef struct {
      string      name;
      logic       ack;
      logic       breq;
      logic       stall;
      logic [1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input string fld, input logic [1:0] act, input logic [1:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge misc_clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "ack",   {1'b0, ifu_iu_lockup_ack}, {1'b0, e.ack});
         chk(e.name, "breq",  {1'b0, ifu_bus_req},       {1'b0, e.breq});
         chk(e.name, "stall", {1'b0, ifu_pref_stall},    {1'b0, e.stall});
         chk(e.name, "cnt",   ifu_lockup_outst_cnt,      e.cnt);
      end
   end

   task automatic push(input string nm, input logic a, input logic b, input logic s, input logic [1:0] c);
      exp_t e;
      e.name = nm; e.ack = a; e.breq = b; e.stall = s; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rq, input logic mk, input logic on,
                        input logic pf, input logic gn, input logic cp);
      iu_ifu_lockup_req   = rq;
      iu_ifu_lockup_mask  = mk;
      iu_ifu_lockup_on    = on;
      pref_ifu_req        = pf;
      bus_ifu_grnt        = gn;
      bus_ifu_trans_cmplt = cp;
   endtask

   // One clock cycle: inputs req,mask,on,pref,grnt,cmplt; expected ack,breq,stall,cnt.
   task automatic cyc(input string nm,
                      input logic rq, input logic mk, input logic on,
                      input logic pf, input logic gn, input logic cp,
                      input logic ea, input logic eb, input logic es, input logic [1:0] ec);
      @(posedge misc_clk);
      #1;
      drive(rq, mk, on, pf, gn, cp);
      push(nm, ea, eb, es, ec);
   endtask

   // Reset asserted between edges; the check lands before any rising edge.
   task automatic rst_pulse(input string nm);
      @(posedge misc_clk);
      #1;
      cpurst_b = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(nm, 1'b0, 1'b0, 1'b1, 2'd0);
      @(negedge misc_clk);
      #1;
      cpurst_b = 1'b1;
   endtask

   initial begin
      cpurst_b = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("reset", 1'b0, 1'b0, 1'b1, 2'd0);
      @(negedge misc_clk);
      #1;
      cpurst_b = 1'b1;

      //   name          rq mk on pf gn cp   ack breq stall cnt
      cyc("t1_req",      1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd0);
      cyc("t1_drain",    1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd0);
      cyc("t1_ack",      1, 0, 0, 1, 0, 0,   1, 0, 1, 2'd0);
      cyc("t1_drop",     0, 1, 1, 1, 0, 0,   1, 0, 1, 2'd0);
      cyc("t1_lock",     0, 1, 1, 1, 0, 0,   0, 0, 1, 2'd0);

      cyc("t5_nmi",      1, 1, 1, 0, 0, 0,   0, 0, 0, 2'd0);
      cyc("t5_drain",    1, 1, 1, 0, 0, 0,   0, 0, 0, 2'd0);
      cyc("t5_ack",      1, 1, 1, 0, 0, 0,   1, 0, 0, 2'd0);
      cyc("t5_drop",     0, 1, 1, 0, 0, 0,   1, 0, 0, 2'd0);
      cyc("t5_lock",     0, 1, 1, 1, 0, 0,   0, 0, 1, 2'd0);

      cyc("t4_unmask",   0, 0, 0, 1, 0, 0,   0, 0, 1, 2'd0);
      cyc("t4_idle",     0, 0, 0, 1, 0, 0,   0, 1, 0, 2'd0);

      cyc("t3_g1",       0, 0, 0, 1, 1, 0,   0, 1, 0, 2'd0);
      cyc("t3_gc",       0, 0, 0, 1, 1, 1,   0, 1, 0, 2'd1);
      cyc("t3_g2",       0, 0, 0, 1, 1, 0,   0, 1, 0, 2'd1);
      cyc("t3_full",     0, 0, 0, 1, 1, 0,   0, 0, 1, 2'd2);

      cyc("t2_c0",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd2);
      cyc("t2_c1",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd2);
      cyc("t2_c2",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd2);
      cyc("t2_c3",       1, 0, 0, 1, 0, 1,   0, 0, 1, 2'd2);
      cyc("t2_c4",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd1);
      cyc("t2_c5",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd1);
      cyc("t2_c6",       1, 0, 0, 1, 0, 1,   0, 0, 1, 2'd1);
      cyc("t2_c7",       1, 0, 0, 1, 0, 0,   0, 0, 1, 2'd0);
      cyc("t2_c8",       1, 0, 0, 1, 0, 0,   1, 0, 1, 2'd0);
      cyc("t2_c9",       0, 0, 0, 1, 0, 0,   1, 0, 1, 2'd0);
      cyc("t2_c10",      0, 0, 0, 1, 1, 0,   0, 1, 0, 2'd0);

      cyc("t6_g2",       0, 0, 0, 1, 1, 0,   0, 1, 0, 2'd1);
      cyc("t6_req",      1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd2);
      cyc("t6_drain",    1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd2);
      rst_pulse("t6_rst");
      cyc("t6_cmplt",    0, 0, 0, 0, 0, 1,   0, 0, 0, 2'd0);
      cyc("t6_after",    0, 0, 0, 1, 0, 0,   0, 1, 0, 2'd0);

      begin : drain_q
         int waited;
         waited = 0;
         while (exp_q.size() > 0 && waited < 20) begin
            @(posedge misc_clk);
            waited++;
         end
         if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain_q: %0d entries left, expected 0", exp_q.size());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
